// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: bank state type and index helpers shared by the reorder buffer
package fft_reorder_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
  localparam int BR_W  = 16;
  localparam int BR_AW = 4;
  function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] idx, input int lg);
    logic [BR_W-1:0] r;
    r = '0;
    for (int k = 0; k < BR_W; k++)
      if (k < lg) r[BR_AW'(k)] = idx[BR_AW'(lg - 1 - k)];
    return r;
  endfunction
  function automatic int clamp_lg(input int lg, input int lo, input int hi);
    return lg < lo ? lo : lg > hi ? hi : lg;
  endfunction
endpackage

// File: rtl/fft_reorder_mem.sv
// fft_reorder_mem: simple dual-port RAM, registered read with enable; address MSB selects the bank
module fft_reorder_mem
  import fft_reorder_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [1<<AW];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong natural-to-bit-reversed reorder buffer with per-frame size and backpressure
// Optional FFT_REORDER_SHIFT_EN adds i_shift, latched per frame, to fftshift the output frame.
module fft_reorder_buf
  import fft_reorder_pkg::*;
#(
  parameter int LGMAX = 6,
  parameter int LGMIN = 3,
  parameter int WIDTH = 16,
  localparam int LGW  = $clog2(LGMAX + 1),
  localparam int DW   = 2 * WIDTH
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [LGW-1:0] i_lgsize,
`ifdef FFT_REORDER_SHIFT_EN
  input  logic           i_shift,
`endif
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [DW-1:0]  i_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [DW-1:0]  o_data,
  output logic           o_first,
  output logic           o_last
);
  bank_state_t      r_st [2];
  logic [LGW-1:0]   r_lg [2];
  logic             r_wb, r_rb;
  logic [LGMAX-1:0] r_wcnt, r_rcnt;
  logic             r_v1, r_f1, r_l1, r_ov, r_of, r_ol;
  logic [DW-1:0]    r_od;
  logic [DW-1:0]    w_q;
  logic [LGW-1:0]   w_clg, w_wlg, w_rlg;
  logic [LGMAX-1:0] w_wmax, w_rmax, w_half, w_raddr;
  logic             w_wr, w_rd, w_adv, w_wlast, w_rlast;
  assign w_clg   = LGW'(clamp_lg(int'(i_lgsize), LGMIN, LGMAX));
  assign o_ready = r_st[r_wb] == EMPTY || r_st[r_wb] == FILLING;
  assign w_wr    = i_valid && o_ready;
  assign w_wlg   = r_wcnt == '0 ? w_clg : r_lg[r_wb];
  assign w_wmax  = LGMAX'((1 << w_wlg) - 1);
  assign w_wlast = r_wcnt == w_wmax;
  assign w_rlg   = r_lg[r_rb];
  assign w_rmax  = LGMAX'((1 << w_rlg) - 1);
  assign w_rlast = r_rcnt == w_rmax;
  // the whole read pipeline advances together whenever the output register can take a word
  assign w_adv   = !r_ov || i_ready;
  assign w_rd    = w_adv && (r_st[r_rb] == FULL || r_st[r_rb] == DRAINING);
`ifdef FFT_REORDER_SHIFT_EN
  logic r_sh [2];
  // flipping the top index bit before reversal swaps the two output halves (DC to centre)
  assign w_half  = r_sh[r_rb] ? LGMAX'(1 << (w_rlg - 1'b1)) : '0;
`else
  assign w_half  = '0;
`endif
  assign w_raddr = LGMAX'(bitrev(BR_W'(r_rcnt ^ w_half), int'(w_rlg)));
  assign o_valid = r_ov;
  assign o_data  = r_od;
  assign o_first = r_of;
  assign o_last  = r_ol;
  fft_reorder_mem #(.AW(LGMAX + 1), .DW(DW)) u_mem (
    .i_clk  (i_clk),
    .i_we   (w_wr),
    .i_waddr({r_wb, r_wcnt}),
    .i_wdata(i_data),
    .i_re   (w_rd),
    .i_raddr({r_rb, w_raddr}),
    .o_rdata(w_q)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_st[0] <= EMPTY;
      r_st[1] <= EMPTY;
      r_lg[0] <= '0;
      r_lg[1] <= '0;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_v1    <= 1'b0;
      r_f1    <= 1'b0;
      r_l1    <= 1'b0;
      r_ov    <= 1'b0;
      r_of    <= 1'b0;
      r_ol    <= 1'b0;
      r_od    <= '0;
    end else begin
      if (w_wr) begin
        if (r_wcnt == '0) r_lg[r_wb] <= w_clg;
        r_st[r_wb] <= w_wlast ? FULL : FILLING;
        r_wcnt     <= w_wlast ? '0 : r_wcnt + 1'b1;
        if (w_wlast) r_wb <= !r_wb;
      end
      if (w_rd) begin
        r_st[r_rb] <= w_rlast ? EMPTY : DRAINING;
        r_rcnt     <= w_rlast ? '0 : r_rcnt + 1'b1;
        if (w_rlast) r_rb <= !r_rb;
      end
      if (w_adv) begin
        r_v1 <= w_rd;
        r_f1 <= r_rcnt == '0;
        r_l1 <= w_rlast;
        r_ov <= r_v1;
        r_of <= r_v1 && r_f1;
        r_ol <= r_v1 && r_l1;
        if (r_v1) r_od <= w_q;
      end
    end
  end
`ifdef FFT_REORDER_SHIFT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sh[0] <= 1'b0;
      r_sh[1] <= 1'b0;
    end else if (w_wr && r_wcnt == '0) begin
      r_sh[r_wb] <= i_shift;
    end
  end
`endif
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: scoreboard bench for fft_reorder_buf (shift cases run when FFT_REORDER_SHIFT_EN is defined)
module tb_fft_reorder_buf;
  localparam int LGMAX = 6;
  localparam int WIDTH = 16;
  localparam int LGW   = $clog2(LGMAX + 1);
  localparam int DW    = 2 * WIDTH;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic [LGW-1:0] i_lgsize = 3;
  logic [DW-1:0] i_data = '0;
`ifdef FFT_REORDER_SHIFT_EN
  logic i_shift = 1'b0;
`endif
  logic o_ready, o_valid, o_first, o_last;
  logic [DW-1:0] o_data;
  logic [DW+1:0] sb [$];
  logic [DW+1:0] e;
  int total = 0, bad = 0, cyc = 0, n_acc = 0, n_pop = 0;
  int t_wr = 0, t_v = -1, t_p1 = 0, t_pn = 0, tw = 0;
  bit drv_done = 1'b0;
  fft_reorder_buf #(.LGMAX(LGMAX), .LGMIN(3), .WIDTH(WIDTH)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_lgsize (i_lgsize),
`ifdef FFT_REORDER_SHIFT_EN
    .i_shift  (i_shift),
`endif
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_first  (o_first),
    .o_last   (o_last)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int brev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction
  task automatic put_word(input int d, input int lg_drv, input bit sh);
    i_valid  = 1'b1;
    i_data   = DW'(d);
    i_lgsize = LGW'(lg_drv);
`ifdef FFT_REORDER_SHIFT_EN
    i_shift  = sh;
`endif
    for (int n = 0; n < 2000; n++) begin
      @(negedge i_clk);
      if (o_ready) break;
    end
    check("wr_accept", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    n_acc++;
    t_wr = cyc;
  endtask
  task automatic send_frame(input int lg_drv, input int lg, input int base, input int alt_drv, input bit sh);
    int n = 1 << lg;
    for (int k = 0; k < n; k++)
      put_word(base + k, (alt_drv >= 0 && k >= n / 2) ? alt_drv : lg_drv, sh);
    for (int k = 0; k < n; k++)
      sb.push_back({k == 0, k == n - 1, DW'(base + brev(sh ? k ^ (n / 2) : k, lg))});
  endtask
  task automatic wait_drain(input string tag);
    for (int n = 0; n < 3000 && sb.size() != 0; n++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    #1;
    check(tag, sb.size(), 0);
    check({tag, "_idle"}, o_valid, 0);
  endtask
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_valid && t_v < 0) t_v = cyc;
      if (o_valid && i_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", o_data, e[DW-1:0]);
          check("first", o_first, e[DW+1]);
          check("last", o_last, e[DW]);
        end
        n_pop++;
        if (n_pop == 1) t_p1 = cyc;
        t_pn = cyc;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog bad=%0d", bad);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_first", o_first, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_data", o_data, 0);
    i_reset_n = 1'b1;
    t_v = -1;
    send_frame(3, 3, 0, -1, 0);
    tw = t_wr;
    wait_drain("t1_drain");
    check("t1_latency", t_v - tw, 2);
    n_pop = 0;
    send_frame(6, 6, 0, -1, 0);
    send_frame(7, 6, 64, -1, 0);
    wait_drain("t2_drain");
    check("t2_count", n_pop, 128);
    check("t2_gap", t_pn - t_p1, 127);
    i_ready = 1'b0;
    n_acc = 0;
    drv_done = 1'b0;
    fork
      begin
        send_frame(3, 3, 0, -1, 0);
        send_frame(3, 3, 8, -1, 0);
        send_frame(3, 3, 16, -1, 0);
        drv_done = 1'b1;
      end
    join_none
    repeat (100) @(posedge i_clk);
    #1;
    check("t3_hold_data_a", o_data, 0);
    repeat (100) @(posedge i_clk);
    #1;
    check("t3_hold_data_b", o_data, 0);
    check("t3_hold_valid", o_valid, 1);
    check("t3_hold_first", o_first, 1);
    check("t3_ready_low", o_ready, 0);
    check("t3_accepted", n_acc, 16);
    i_ready = 1'b1;
    for (int n = 0; n < 2000 && !drv_done; n++) @(posedge i_clk);
    #1;
    check("t3_drv_done", drv_done, 1);
    wait_drain("t3_drain");
    send_frame(1, 3, 100, -1, 0);
    send_frame(0, 3, 120, -1, 0);
    wait_drain("clamp_drain");
    send_frame(4, 4, 200, 3, 0);
    send_frame(3, 3, 300, -1, 0);
    wait_drain("t4_drain");
    fork
      begin
        repeat (120) begin
          @(posedge i_clk);
          #1;
          i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
      begin
        send_frame(4, 4, 400, -1, 0);
        send_frame(3, 3, 500, -1, 0);
        send_frame(4, 4, 600, -1, 0);
      end
    join
    wait_drain("bp_drain");
    for (int k = 0; k < 5; k++) put_word(k + 50, 3, 0);
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    check("t5_o_valid", o_valid, 0);
    check("t5_o_ready", o_ready, 1);
    send_frame(3, 3, 0, -1, 0);
    wait_drain("t5_drain");
`ifdef FFT_REORDER_SHIFT_EN
    send_frame(3, 3, 0, -1, 1);
    send_frame(4, 4, 700, -1, 1);
    wait_drain("t6_drain");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
